// File: rtl/wbl_array_writer.sv
// Streams every WBL word from wbl_key_gen into the DRAM-CIM write-bitline port,
// row-major, one word per valid/ready beat tagged with its row and column.
module wbl_array_writer #(
    parameter int WORD_W  = 64,
    parameter int NUM_COL = 16,
    parameter int NUM_ROW = 64,
    parameter int ROW_W   = $clog2(NUM_ROW),
    parameter int COL_W   = $clog2(NUM_COL)
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      START,
    input  logic                      GEN_DONE,
    output logic [ROW_W-1:0]          GEN_ADDR,
    input  logic [NUM_COL*WORD_W-1:0] WBL_FLAT,
    output logic                      WR_VALID,
    input  logic                      WR_READY,
    output logic [ROW_W-1:0]          WR_ROW,
    output logic [COL_W-1:0]          WR_COL,
    output logic [WORD_W-1:0]         WR_DATA,
    output logic                      BUSY,
    output logic                      DONE,
    output logic                      ERR,
    output logic [2:0]                DBG_STATE
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_GEN = 3'd1,
        S_LOAD     = 3'd2,
        S_STREAM   = 3'd3,
        S_FIN      = 3'd4
    } state_t;

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROW - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COL - 1);

    state_t                      state, state_nx;
    logic [ROW_W-1:0]            row, row_nx;
    logic [COL_W-1:0]            col, col_nx;
    logic                        done_r, done_nx;
    logic                        err_r, err_nx;
    logic                        cap_en;
    logic [NUM_COL*WORD_W-1:0]   cap;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= S_IDLE;
            row    <= '0;
            col    <= '0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
            cap    <= '0;
        end else begin
            state  <= state_nx;
            row    <= row_nx;
            col    <= col_nx;
            done_r <= done_nx;
            err_r  <= err_nx;
            if (cap_en) cap <= WBL_FLAT;
        end
    end

    // Handshake: a beat transfers on the rising edge where WR_VALID and WR_READY
    // are both high; while WR_READY is low, WR_VALID stays high and
    // WR_ROW/WR_COL/WR_DATA hold. Losing GEN_DONE aborts before any transfer.
    always_comb begin
        state_nx = state;
        row_nx   = row;
        col_nx   = col;
        done_nx  = done_r;
        err_nx   = err_r;
        cap_en   = 1'b0;
        case (state)
            S_IDLE, S_FIN: begin
                if (START) begin
                    state_nx = S_WAIT_GEN;
                    row_nx   = '0;
                    col_nx   = '0;
                    done_nx  = 1'b0;
                    err_nx   = 1'b0;
                end
            end
            S_WAIT_GEN: begin
                if (GEN_DONE) state_nx = S_LOAD;
            end
            S_LOAD: begin
                if (!GEN_DONE) begin
                    state_nx = S_IDLE;
                    err_nx   = 1'b1;
                end else begin
                    cap_en   = 1'b1;
                    col_nx   = '0;
                    state_nx = S_STREAM;
                end
            end
            S_STREAM: begin
                if (!GEN_DONE) begin
                    state_nx = S_IDLE;
                    err_nx   = 1'b1;
                end else if (WR_READY) begin
                    if (col != COL_LAST) begin
                        col_nx = col + 1'b1;
                    end else if (row != ROW_LAST) begin
                        row_nx   = row + 1'b1;
                        col_nx   = '0;
                        state_nx = S_LOAD;
                    end else begin
                        state_nx = S_FIN;
                        done_nx  = 1'b1;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign GEN_ADDR  = row;
    assign WR_VALID  = (state == S_STREAM);
    assign WR_ROW    = row;
    assign WR_COL    = col;
    assign WR_DATA   = cap[col*WORD_W +: WORD_W];
    assign BUSY      = (state == S_WAIT_GEN) || (state == S_LOAD) || (state == S_STREAM);
    assign DONE      = done_r;
    assign ERR       = err_r;
    assign DBG_STATE = state;

endmodule

// File: tb/tb_wbl_array_writer.sv
// Bench for wbl_array_writer: a behavioural key generator feeds WBL_FLAT and a
// scoreboard of expected {row, col, word} beats is checked at each transfer.
module tb_wbl_array_writer;

    localparam int WORD_W  = 64;
    localparam int NUM_COL = 16;
    localparam int NUM_ROW = 64;
    localparam int NBEATS  = NUM_COL * NUM_ROW;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WAIT   = 3'd1;
    localparam logic [2:0] ST_LOAD   = 3'd2;
    localparam logic [2:0] ST_STREAM = 3'd3;

    logic clk = 1'b0;
    logic rst, start, gen_done, wr_ready;
    logic wr_valid, busy, done, err;
    logic [5:0] gen_addr, wr_row;
    logic [3:0] wr_col;
    logic [63:0] wr_data;
    logic [NUM_COL*WORD_W-1:0] wbl_flat;
    logic [2:0] dbg_state;

    logic [73:0] exp_q[$];
    int n_checks = 0;
    int n_pass = 0;
    int beats = 0;
    bit bp_mode = 1'b0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    wbl_array_writer dut (
        .CLK(clk), .RST(rst), .START(start), .GEN_DONE(gen_done),
        .GEN_ADDR(gen_addr), .WBL_FLAT(wbl_flat),
        .WR_VALID(wr_valid), .WR_READY(wr_ready),
        .WR_ROW(wr_row), .WR_COL(wr_col), .WR_DATA(wr_data),
        .BUSY(busy), .DONE(done), .ERR(err), .DBG_STATE(dbg_state)
    );

    // Generator model: word depends on the address being presented.
    function automatic logic [63:0] gen_word(input logic [5:0] r, input logic [3:0] c);
        logic [63:0] x;
        x = 64'({r, c}) + 64'd1;
        return (x * 64'h9E3779B97F4A7C15) ^ (x << 40);
    endfunction

    for (genvar c = 0; c < NUM_COL; c++) begin : g_gen
        assign wbl_flat[c*WORD_W +: WORD_W] = gen_word(gen_addr, 4'(c));
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        exp_q.delete();
        for (int r = 0; r < NUM_ROW; r++)
            for (int c = 0; c < NUM_COL; c++)
                exp_q.push_back({6'(r), 4'(c), gen_word(6'(r), 4'(c))});
        beats = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, done, 1'b1);
    endtask

    task automatic wait_beat(input string tag, input logic [5:0] r, input logic [3:0] c);
        int n;
        n = 0;
        while (!(wr_valid && wr_row == r && wr_col == c) && n < 3000) begin
            tick();
            n++;
        end
        check({tag, "_reached"}, {wr_valid, wr_row, wr_col}, {1'b1, r, c});
    endtask

    task automatic end_checks(input string tag);
        check({tag, "_beats"}, beats, NBEATS);
        check({tag, "_queue_left"}, exp_q.size(), 0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_valid"}, wr_valid, 1'b0);
        check({tag, "_err"}, err, 1'b0);
        tick();
        check({tag, "_done_hold"}, done, 1'b1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_state"}, dbg_state, ST_IDLE);
        check({tag, "_gen_addr"}, gen_addr, 6'd0);
        check({tag, "_valid"}, wr_valid, 1'b0);
        check({tag, "_row"}, wr_row, 6'd0);
        check({tag, "_col"}, wr_col, 4'd0);
        check({tag, "_data"}, wr_data, 64'd0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_err"}, err, 1'b0);
    endtask

    initial begin
        wr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            wr_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------- scoreboard / monitor ----------------
    initial begin
        logic        stall_pend;
        logic [73:0] stall_tuple, obs, exp;
        stall_pend = 1'b0;
        stall_tuple = '0;
        forever begin
            @(negedge clk);
            obs = {wr_row, wr_col, wr_data};
            if (rst) begin
                stall_pend = 1'b0;
            end else begin
                if (stall_pend && wr_valid) check("stall_hold", obs, stall_tuple);
                stall_pend = 1'b0;
                if (wr_valid && gen_done) begin
                    if (wr_ready) begin
                        beats++;
                        check("beat_expected", exp_q.size() > 0, 1'b1);
                        if (exp_q.size() > 0) begin
                            exp = exp_q.pop_front();
                            check("beat", obs, exp);
                        end
                    end else begin
                        stall_pend  = 1'b1;
                        stall_tuple = obs;
                    end
                end
            end
        end
    end

    // ---------------- scenarios ----------------
    initial begin
        int cnt;
        rst = 1'b1;
        start = 1'b0;
        gen_done = 1'b0;
        repeat (3) tick();
        check_zero("reset");
        rst = 1'b0;
        tick();

        // Golden stream, full throughput
        gen_done = 1'b1;
        start_run();
        check("lat_wait_state", dbg_state, ST_WAIT);
        check("lat_wait_valid", wr_valid, 1'b0);
        check("lat_wait_busy", busy, 1'b1);
        tick();
        check("lat_load_state", dbg_state, ST_LOAD);
        check("lat_load_valid", wr_valid, 1'b0);
        tick();
        check("lat_first_valid", wr_valid, 1'b1);
        // first-valid cycle through first-DONE cycle, inclusive
        cnt = 1;
        while (!done && cnt < 3000) begin
            tick();
            cnt++;
        end
        check("done_latency", cnt, 1088);
        end_checks("golden");

        // Random backpressure
        bp_mode = 1'b1;
        start_run();
        wait_done("bp", 6000);
        bp_mode = 1'b0;
        end_checks("bp");

        // Late generator
        gen_done = 1'b0;
        start_run();
        for (int i = 0; i < 30; i++) begin
            check("late_valid", wr_valid, 1'b0);
            check("late_gen_addr", gen_addr, 6'd0);
            check("late_busy", busy, 1'b1);
            tick();
        end
        gen_done = 1'b1;
        wait_done("late", 3000);
        end_checks("late");

        // Abort at row 5 col 7, then a clean rerun
        start_run();
        wait_beat("abort", 6'd5, 4'd7);
        gen_done = 1'b0;
        tick();
        check("abort_state", dbg_state, ST_IDLE);
        check("abort_valid", wr_valid, 1'b0);
        check("abort_err", err, 1'b1);
        check("abort_done", done, 1'b0);
        check("abort_busy", busy, 1'b0);
        tick();
        check("abort_err_sticky", err, 1'b1);
        gen_done = 1'b1;
        start_run();
        check("abort_err_cleared", err, 1'b0);
        wait_done("abort_rerun", 3000);
        end_checks("abort_rerun");

        // Reset mid-stream at row 20
        start_run();
        wait_beat("rst_mid", 6'd20, 4'd0);
        rst = 1'b1;
        tick();
        check_zero("rst_mid");
        rst = 1'b0;
        tick();
        start_run();
        wait_done("rst_rerun", 3000);
        end_checks("rst_rerun");

        // START while busy is ignored
        start_run();
        wait_beat("ign", 6'd10, 4'd3);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ign_state", dbg_state, ST_STREAM);
        check("ign_busy", busy, 1'b1);
        check("ign_pos", {wr_row, wr_col}, {6'd10, 4'd4});
        wait_done("ign", 3000);
        end_checks("ign");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
